// File: rtl/toysram_16x12_port_ctrl_pkg.sv
// Shared constants, write-FSM state type and row decode helpers for the toysram port controller.
package toysram_pkg;

    localparam int unsigned ROWS   = 16;
    localparam int unsigned COLS   = 12;
    localparam int unsigned AW     = 4;
    localparam int unsigned RD_LAT = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        RECOVER = 2'd2
    } wr_state_t;

    // True when the address names a physical row.
    function automatic logic row_hit(input logic [AW-1:0] addr);
        return 32'(addr) < ROWS;
    endfunction

    // Wordline decode: row 0 sits on the MSB of the wordline bus, row ROWS-1 on the LSB.
    function automatic logic [ROWS-1:0] row_onehot(input logic [AW-1:0] addr);
        logic [AW-1:0] idx;
        idx        = AW'(ROWS - 1) - addr;
        row_onehot = '0;
        if (row_hit(addr)) begin
            row_onehot[idx] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/toysram_16x12_port_ctrl_if.sv
// Core-side request/response bundle: two read ports and one write port.
//   master : core request logic (drives valid/addr/data)
//   slave  : port controller (drives ready/rvalid/rdata)
interface toysram_16x12_port_ctrl_if;
    import toysram_pkg::*;

    logic            rd0_valid;
    logic [AW-1:0]   rd0_addr;
    logic            rd0_ready;
    logic            rd0_rvalid;
    logic [COLS-1:0] rd0_rdata;

    logic            rd1_valid;
    logic [AW-1:0]   rd1_addr;
    logic            rd1_ready;
    logic            rd1_rvalid;
    logic [COLS-1:0] rd1_rdata;

    logic            wr_valid;
    logic [AW-1:0]   wr_addr;
    logic [COLS-1:0] wr_data;
    logic            wr_ready;

    modport master (
        output rd0_valid, rd0_addr, rd1_valid, rd1_addr, wr_valid, wr_addr, wr_data,
        input  rd0_ready, rd0_rvalid, rd0_rdata, rd1_ready, rd1_rvalid, rd1_rdata, wr_ready
    );

    modport slave (
        input  rd0_valid, rd0_addr, rd1_valid, rd1_addr, wr_valid, wr_addr, wr_data,
        output rd0_ready, rd0_rvalid, rd0_rdata, rd1_ready, rd1_rvalid, rd1_rdata, wr_ready
    );

endinterface

// File: rtl/toysram_16x12_port_ctrl_rd_port.sv
// One read port: handshake, registered wordline launch, RD_LAT-deep valid pipeline, rdata capture.
//   clk, reset        : clock, synchronous active-high reset
//   valid, addr       : read request
//   hazard            : row currently owned by the write path
//   ready             : request can be accepted this cycle
//   rwl               : one-hot read wordline, high the cycle after acceptance
//   rbl               : latched read bitlines from the array wrapper
//   rvalid, rdata     : response, RD_LAT edges after acceptance
module toysram_rd_port
    import toysram_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            valid,
    input  logic [AW-1:0]   addr,
    input  logic            hazard,
    output logic            ready,
    output logic [ROWS-1:0] rwl,
    input  logic [COLS-1:0] rbl,
    output logic            rvalid,
    output logic [COLS-1:0] rdata
);

    logic              accept;
    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] hit_q;

    assign ready  = !reset && !hazard;
    assign accept = valid && ready;

    // Launch wordline, track in-flight reads, capture the wrapper latch at the last stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            rwl    <= '0;
            vld_q  <= '0;
            hit_q  <= '0;
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rwl    <= accept ? row_onehot(addr) : '0;
            vld_q  <= {vld_q[RD_LAT-2:0], accept};
            hit_q  <= {hit_q[RD_LAT-2:0], accept && row_hit(addr)};
            rvalid <= vld_q[RD_LAT-1];
            if (vld_q[RD_LAT-1]) begin
                // Out-of-range rows fired no wordline, so the bitlines are stale: return zero.
                rdata <= hit_q[RD_LAT-1] ? rbl : '0;
            end
        end
    end

endmodule

// File: rtl/toysram_16x12_port_ctrl.sv
// Port controller for the 16x12 toysram wrapper: two read ports, one write port with a
// DRIVE/RECOVER write sequence, read/write row-collision blocking and array-side invariants.
//   clk, reset          : clock, synchronous active-high reset
//   bus                 : core-side request/response bundle (slave side)
//   rwl0, rwl1          : read wordlines (one-hot or zero)
//   rbl0, rbl1          : latched read bitlines from the wrapper
//   wwl0                : write wordline (one-hot or zero)
//   wbl0, wbl0_b        : write bitlines, true and complement
module toysram_16x12_port_ctrl
    import toysram_pkg::*;
#(
    parameter int unsigned WR_CYC = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    toysram_16x12_port_ctrl_if.slave       bus,
    output logic [ROWS-1:0]                rwl0,
    output logic [ROWS-1:0]                rwl1,
    input  logic [COLS-1:0]                rbl0,
    input  logic [COLS-1:0]                rbl1,
    output logic [ROWS-1:0]                wwl0,
    output logic [COLS-1:0]                wbl0,
    output logic [COLS-1:0]                wbl0_b
);

    localparam int unsigned CNT_W = 3;

    wr_state_t       state_q, state_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ROWS-1:0] wwl_d;
    logic [COLS-1:0] wbl_d, wbl_b_d;

    logic wr_idle;
    logic wr_busy;
    logic wr_fire;
    logic hazard0;
    logic hazard1;

    assign wr_idle      = (state_q == IDLE);
    assign wr_busy      = (state_q == DRIVE) || (state_q == RECOVER);
    assign wr_fire      = bus.wr_valid && wr_idle;
    assign bus.wr_ready = wr_idle;

    // A read may not touch the row being written, nor the row a write is taking this edge.
    assign hazard0 = (wr_busy && (waddr_q == bus.rd0_addr)) || (wr_fire && (bus.wr_addr == bus.rd0_addr));
    assign hazard1 = (wr_busy && (waddr_q == bus.rd1_addr)) || (wr_fire && (bus.wr_addr == bus.rd1_addr));

    toysram_rd_port u_rd0 (
        .clk    (clk),
        .reset  (reset),
        .valid  (bus.rd0_valid),
        .addr   (bus.rd0_addr),
        .hazard (hazard0),
        .ready  (bus.rd0_ready),
        .rwl    (rwl0),
        .rbl    (rbl0),
        .rvalid (bus.rd0_rvalid),
        .rdata  (bus.rd0_rdata)
    );

    toysram_rd_port u_rd1 (
        .clk    (clk),
        .reset  (reset),
        .valid  (bus.rd1_valid),
        .addr   (bus.rd1_addr),
        .hazard (hazard1),
        .ready  (bus.rd1_ready),
        .rwl    (rwl1),
        .rbl    (rbl1),
        .rvalid (bus.rd1_rvalid),
        .rdata  (bus.rd1_rdata)
    );

    // Write FSM state and registered array-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            waddr_q <= '0;
            cnt_q   <= '0;
            wwl0    <= '0;
            wbl0    <= '0;
            wbl0_b  <= '0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            cnt_q   <= cnt_d;
            wwl0    <= wwl_d;
            wbl0    <= wbl_d;
            wbl0_b  <= wbl_b_d;
        end
    end

    // Next state plus next values of the registered wordline/bitlines, aligned with the state.
    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        cnt_d   = cnt_q;
        wwl_d   = '0;
        wbl_d   = wbl0;
        wbl_b_d = wbl0_b;
        case (state_q)
            IDLE: begin
                wbl_d   = '0;
                wbl_b_d = '0;
                if (bus.wr_valid) begin
                    state_d = DRIVE;
                    waddr_d = bus.wr_addr;
                    cnt_d   = '0;
                    wwl_d   = row_onehot(bus.wr_addr);
                    wbl_d   = bus.wr_data;
                    wbl_b_d = ~bus.wr_data;
                end
            end
            DRIVE: begin
                if (cnt_q == CNT_W'(WR_CYC - 1)) begin
                    state_d = RECOVER;
                end else begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                    wwl_d = row_onehot(waddr_q);
                end
            end
            RECOVER: begin
                state_d = IDLE;
                wbl_d   = '0;
                wbl_b_d = '0;
            end
            default: begin
                state_d = IDLE;
                wbl_d   = '0;
                wbl_b_d = '0;
            end
        endcase
    end

    // Array-side electrical invariants.
    a_rwl0_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(rwl0));
    a_rwl1_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(rwl1));
    a_wwl0_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(wwl0));
    a_wbl_idle:    assert property (@(posedge clk) disable iff (reset)
                                    (state_q == IDLE) |-> ((wbl0 & wbl0_b) == '0));
    a_wbl_drive:   assert property (@(posedge clk) disable iff (reset)
                                    (state_q == DRIVE) |-> ((wbl0 ^ wbl0_b) == '1));
    a_rw_row:      assert property (@(posedge clk) disable iff (reset)
                                    ((rwl0 | rwl1) & wwl0) == '0);

endmodule

// File: tb/tb_toysram_16x12_port_ctrl.sv
// Directed and randomized checks of the toysram port controller against a behavioural array.
module tb_toysram_16x12_port_ctrl;
    import toysram_pkg::*;

    logic            clk;
    logic            reset;
    logic            model_seed;
    logic [ROWS-1:0] rwl0, rwl1, wwl0;
    logic [COLS-1:0] rbl0, rbl1, wbl0, wbl0_b;

    toysram_16x12_port_ctrl_if bus ();

    toysram_16x12_port_ctrl #(.WR_CYC(1)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .rwl0   (rwl0),
        .rwl1   (rwl1),
        .rbl0   (rbl0),
        .rbl1   (rbl1),
        .wwl0   (wwl0),
        .wbl0   (wbl0),
        .wbl0_b (wbl0_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Power-on contents: row r holds {r, 8'hC3}.
    function automatic logic [COLS-1:0] row_seed(input int r);
        logic [3:0] rr;
        rr = 4'(r);
        return {rr, 8'hC3};
    endfunction

    // Behavioural array wrapper: read latch and write on the edge ending the wordline cycle.
    logic [COLS-1:0] mem [ROWS];
    always @(posedge clk) begin
        for (int r = 0; r < int'(ROWS); r++) begin
            if (model_seed) mem[r] <= row_seed(r);
            if (rwl0[ROWS-1-r]) rbl0 <= mem[r];
            if (rwl1[ROWS-1-r]) rbl1 <= mem[r];
            if (wwl0[ROWS-1-r]) mem[r] <= wbl0;
        end
    end

    // Scoreboard: expected data is taken from the reference contents at acceptance.
    logic [COLS-1:0] exp_mem [ROWS];
    logic [COLS-1:0] q0 [$];
    logic [COLS-1:0] q1 [$];
    logic [COLS-1:0] e0, e1;

    always @(posedge clk) begin
        if (model_seed) begin
            for (int r = 0; r < int'(ROWS); r++) exp_mem[r] = row_seed(r);
        end
        if (reset) begin
            q0.delete();
            q1.delete();
        end else begin
            if (bus.rd0_valid && bus.rd0_ready) q0.push_back(exp_mem[bus.rd0_addr]);
            if (bus.rd1_valid && bus.rd1_ready) q1.push_back(exp_mem[bus.rd1_addr]);
            if (bus.wr_valid && bus.wr_ready) exp_mem[bus.wr_addr] = bus.wr_data;
        end
    end

    always @(negedge clk) begin
        if (bus.rd0_rvalid) begin
            if (q0.size() == 0) check("sb0_extra_rvalid", 32'd1, 32'd0);
            else begin
                e0 = q0.pop_front();
                check("sb0_data", 32'(bus.rd0_rdata), 32'(e0));
            end
        end
        if (bus.rd1_rvalid) begin
            if (q1.size() == 0) check("sb1_extra_rvalid", 32'd1, 32'd0);
            else begin
                e1 = q1.pop_front();
                check("sb1_data", 32'(bus.rd1_rdata), 32'(e1));
            end
        end
    end

    function automatic logic rd_ready(input int p);
        return (p == 0) ? bus.rd0_ready : bus.rd1_ready;
    endfunction

    function automatic logic rd_rvalid(input int p);
        return (p == 0) ? bus.rd0_rvalid : bus.rd1_rvalid;
    endfunction

    function automatic logic [COLS-1:0] rd_rdata(input int p);
        return (p == 0) ? bus.rd0_rdata : bus.rd1_rdata;
    endfunction

    task automatic set_rd(input int p, input logic v, input logic [AW-1:0] a);
        if (p == 0) begin
            bus.rd0_valid = v;
            bus.rd0_addr  = a;
        end else begin
            bus.rd1_valid = v;
            bus.rd1_addr  = a;
        end
    endtask

    // Called just after the negedge where valid was dropped; response is due two negedges later.
    task automatic wait_resp(input int p, input logic [COLS-1:0] exp, input string tag);
        int k;
        k = 0;
        while (!rd_rvalid(p) && k < 8) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_rvalid"}, 32'(rd_rvalid(p)), 32'd1);
        check({tag, "_rdata"}, 32'(rd_rdata(p)), 32'(exp));
    endtask

    task automatic rd_txn(input int p, input logic [AW-1:0] a, input logic [COLS-1:0] exp,
                          input string tag);
        int k;
        @(negedge clk);
        set_rd(p, 1'b1, a);
        #1;
        k = 0;
        while (!rd_ready(p) && k < 16) begin
            @(negedge clk);
            #1;
            k++;
        end
        check({tag, "_ready"}, 32'(rd_ready(p)), 32'd1);
        @(negedge clk);
        set_rd(p, 1'b0, a);
        wait_resp(p, exp, tag);
    endtask

    function automatic logic [COLS-1:0] stream_exp(input int r);
        case (r)
            3:       return 12'hA5C;
            7:       return 12'h7B2;
            default: return row_seed(r);
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        reset         = 1'b1;
        model_seed    = 1'b1;
        bus.rd0_valid = 1'b0;
        bus.rd0_addr  = '0;
        bus.rd1_valid = 1'b0;
        bus.rd1_addr  = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        repeat (3) @(negedge clk);
        model_seed = 1'b0;

        // Reset state
        check("rst_rwl0", 32'(rwl0), 32'h0);
        check("rst_rwl1", 32'(rwl1), 32'h0);
        check("rst_wwl0", 32'(wwl0), 32'h0);
        check("rst_wbl0", 32'(wbl0), 32'h0);
        check("rst_wbl0_b", 32'(wbl0_b), 32'h0);
        check("rst_rvalid0", 32'(bus.rd0_rvalid), 32'h0);
        check("rst_rdata0", 32'(bus.rd0_rdata), 32'h0);
        check("rst_rdata1", 32'(bus.rd1_rdata), 32'h0);
        check("rst_rd0_ready", 32'(bus.rd0_ready), 32'h0);
        check("rst_wr_ready", 32'(bus.wr_ready), 32'h1);
        reset = 1'b0;

        // Single read of row 5: exact wordline and response timing
        @(negedge clk);
        set_rd(0, 1'b1, 4'd5);
        #1 check("r5_ready", 32'(bus.rd0_ready), 32'h1);
        @(negedge clk);
        set_rd(0, 1'b0, 4'd5);
        check("r5_rwl0_launch", 32'(rwl0), 32'h0400);
        check("r5_rvalid_e1", 32'(bus.rd0_rvalid), 32'h0);
        @(negedge clk);
        check("r5_rwl0_off", 32'(rwl0), 32'h0);
        check("r5_rvalid_e2", 32'(bus.rd0_rvalid), 32'h0);
        @(negedge clk);
        check("r5_rvalid", 32'(bus.rd0_rvalid), 32'h1);
        check("r5_rdata", 32'(bus.rd0_rdata), 32'h5C3);
        @(negedge clk);
        check("r5_rvalid_pulse", 32'(bus.rd0_rvalid), 32'h0);

        // Write row 3 with A5C: DRIVE then RECOVER
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 4'd3;
        bus.wr_data  = 12'hA5C;
        #1 check("w3_ready", 32'(bus.wr_ready), 32'h1);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        check("w3_drive_wwl0", 32'(wwl0), 32'h1000);
        check("w3_drive_wbl0", 32'(wbl0), 32'hA5C);
        check("w3_drive_wbl0_b", 32'(wbl0_b), 32'h5A3);
        check("w3_drive_ready", 32'(bus.wr_ready), 32'h0);
        @(negedge clk);
        check("w3_rec_wwl0", 32'(wwl0), 32'h0);
        check("w3_rec_wbl0", 32'(wbl0), 32'hA5C);
        check("w3_rec_wbl0_b", 32'(wbl0_b), 32'h5A3);
        check("w3_rec_ready", 32'(bus.wr_ready), 32'h0);
        @(negedge clk);
        check("w3_idle_ready", 32'(bus.wr_ready), 32'h1);
        check("w3_idle_wbl0", 32'(wbl0), 32'h0);
        check("w3_idle_wbl0_b", 32'(wbl0_b), 32'h0);
        rd_txn(0, 4'd3, 12'hA5C, "r3_after_w");

        // Same-row collision: write row 7 wins, read waits for IDLE and sees new data
        @(negedge clk);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 4'd7;
        bus.wr_data  = 12'h3E1;
        set_rd(1, 1'b1, 4'd7);
        #1;
        check("col_rd1_blk_accept", 32'(bus.rd1_ready), 32'h0);
        check("col_wr_ready", 32'(bus.wr_ready), 32'h1);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        #1 check("col_rd1_blk_drive", 32'(bus.rd1_ready), 32'h0);
        @(negedge clk);
        #1 check("col_rd1_blk_recover", 32'(bus.rd1_ready), 32'h0);
        @(negedge clk);
        #1 check("col_rd1_ready_idle", 32'(bus.rd1_ready), 32'h1);
        @(negedge clk);
        set_rd(1, 1'b0, 4'd7);
        wait_resp(1, 12'h3E1, "col_r7");

        // Different rows in the same cycle: both accepted
        @(negedge clk);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 4'd7;
        bus.wr_data  = 12'h7B2;
        set_rd(1, 1'b1, 4'd8);
        #1;
        check("par_rd1_ready", 32'(bus.rd1_ready), 32'h1);
        check("par_wr_ready", 32'(bus.wr_ready), 32'h1);
        @(negedge clk);
        bus.wr_valid = 1'b0;
        set_rd(1, 1'b0, 4'd8);
        check("par_wwl0", 32'(wwl0), 32'h0100);
        check("par_rwl1", 32'(rwl1), 32'h0080);
        wait_resp(1, 12'h8C3, "par_r8");
        rd_txn(1, 4'd7, 12'h7B2, "par_r7");

        // Both ports streaming 16 rows back to back
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c >= 3 && c < 19) begin
                check("st0_rvalid", 32'(bus.rd0_rvalid), 32'h1);
                check("st0_rdata", 32'(bus.rd0_rdata), 32'(stream_exp(c - 3)));
                check("st1_rvalid", 32'(bus.rd1_rvalid), 32'h1);
                check("st1_rdata", 32'(bus.rd1_rdata), 32'(stream_exp(18 - c)));
            end else begin
                check("st0_idle", 32'(bus.rd0_rvalid), 32'h0);
                check("st1_idle", 32'(bus.rd1_rvalid), 32'h0);
            end
            if (c < 16) begin
                set_rd(0, 1'b1, 4'(c));
                set_rd(1, 1'b1, 4'(15 - c));
            end else begin
                set_rd(0, 1'b0, 4'd0);
                set_rd(1, 1'b0, 4'd0);
            end
        end

        // Reset one cycle after a read accept, while the write is in DRIVE
        @(negedge clk);
        set_rd(0, 1'b1, 4'd2);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 4'd9;
        bus.wr_data  = 12'h9A9;
        @(negedge clk);
        set_rd(0, 1'b0, 4'd2);
        bus.wr_valid = 1'b0;
        check("mr_drive_wwl0", 32'(wwl0), 32'h0040);
        reset = 1'b1;
        @(negedge clk);
        check("mr_rwl0", 32'(rwl0), 32'h0);
        check("mr_wwl0", 32'(wwl0), 32'h0);
        check("mr_wbl0", 32'(wbl0), 32'h0);
        check("mr_rvalid0", 32'(bus.rd0_rvalid), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check("mr_wr_ready", 32'(bus.wr_ready), 32'h1);
        check("mr_no_rvalid_a", 32'(bus.rd0_rvalid), 32'h0);
        @(negedge clk);
        check("mr_no_rvalid_b", 32'(bus.rd0_rvalid), 32'h0);
        rd_txn(0, 4'd9, 12'h9A9, "mr_rewrite_chk");

        // Mixed random traffic, checked by the scoreboard
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            set_rd(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            set_rd(1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            bus.wr_valid = ($urandom_range(0, 2) == 0);
            bus.wr_addr  = 4'($urandom_range(0, 15));
            bus.wr_data  = 12'($urandom_range(0, 4095));
        end
        @(negedge clk);
        set_rd(0, 1'b0, 4'd0);
        set_rd(1, 1'b0, 4'd0);
        bus.wr_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("drain_q0", 32'(q0.size()), 32'd0);
        check("drain_q1", 32'(q1.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
